// File: rtl/maxpool2x2_stream_if.sv
// Pixel stream bundle for maxpool2x2_stream: input and output valid/ready channels.
// master drives in_data/in_valid/out_ready; slave (the pooling engine) drives in_ready/out_data/out_valid.
interface maxpool2x2_stream_if #(
    parameter int DATA_W = 32
);
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool with optional per-frame ReLU.
// Ports: clk, reset (sync, active-high), start, relu_en, busy, done, s (stream slave).
module maxpool2x2_stream #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   relu_en,
    output logic                   busy,
    output logic                   done,
    maxpool2x2_stream_if.slave     s
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int KD = IMG_W / 2;
    localparam int KW = (KD > 1) ? $clog2(KD) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef logic signed [DATA_W-1:0] pix_t;

    function automatic pix_t smax(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          relu_q, relu_d;
    pix_t          hold_q, hold_d;
    pix_t          out_q, out_d;
    logic          ov_q, ov_d;

    // Half-width line buffer: one pair-max per window column from the even row.
    pix_t          lbuf [KD];

    pix_t          p;
    pix_t          lb_rd;
    pix_t          pool;
    logic [KW-1:0] k;
    logic          in_rdy;
    logic          xfer;
    logic          last;
    logic          lb_we;
    pix_t          lb_wd;

    assign p      = s.in_data;
    assign k      = KW'(col_q >> 1);
    assign lb_rd  = lbuf[k];
    assign in_rdy = (state_q == S_RUN) && (!ov_q || s.out_ready);
    assign xfer   = s.in_valid && in_rdy;
    assign last   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign pool   = smax(hold_q, p);

    assign s.in_ready  = in_rdy;
    assign s.out_data  = out_q;
    assign s.out_valid = ov_q;
    assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        relu_d  = relu_q;
        hold_d  = hold_q;
        out_d   = out_q;
        ov_d    = ov_q;
        lb_we   = 1'b0;
        lb_wd   = pool;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    relu_d  = relu_en;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (xfer && last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (ov_q && s.out_ready) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (ov_q && s.out_ready) ov_d = 1'b0;

        if (xfer) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            unique case ({row_q[0], col_q[0]})
                2'b00: hold_d = p;
                2'b01: lb_we  = 1'b1;
                2'b10: hold_d = smax(lb_rd, p);
                2'b11: begin
                    // A reload in the same cycle as a drain keeps ov high.
                    ov_d  = 1'b1;
                    out_d = (relu_q && pool < 0) ? '0 : pool;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            relu_q  <= 1'b0;
            hold_q  <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            relu_q  <= relu_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we) lbuf[k] <= lb_wd;
    end
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream: a 4x4 and an 8x6 instance on shared stimulus.
// The expected pooled stream is computed from a whole-frame array model.
module tb_maxpool2x2_stream;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic relu_en = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [7:0] in_data = '0;
    logic busy_a, done_a, busy_b, done_b;

    int tests = 0;
    int fails = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int or_mode = 0;

    logic signed [7:0] qa[$];
    logic signed [7:0] qb[$];
    logic signed [7:0] fm[0:63];

    always #5 clk = ~clk;

    maxpool2x2_stream_if #(.DATA_W(8)) ifa ();
    maxpool2x2_stream_if #(.DATA_W(8)) ifb ();

    assign ifa.in_data   = in_data;
    assign ifa.in_valid  = in_valid;
    assign ifa.out_ready = out_ready;
    assign ifb.in_data   = in_data;
    assign ifb.in_valid  = in_valid;
    assign ifb.out_ready = out_ready;

    maxpool2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) u_a (
        .clk     (clk),
        .reset   (reset),
        .start   (start_a),
        .relu_en (relu_en),
        .busy    (busy_a),
        .done    (done_a),
        .s       (ifa)
    );

    maxpool2x2_stream #(.DATA_W(8), .IMG_W(8), .IMG_H(6)) u_b (
        .clk     (clk),
        .reset   (reset),
        .start   (start_b),
        .relu_en (relu_en),
        .busy    (busy_b),
        .done    (done_b),
        .s       (ifb)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops and compares on every output transfer.
    always @(negedge clk) begin
        if (!reset && ifa.out_valid && out_ready) begin
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out_a_extra: got %0d expected none", ifa.out_data);
            end else begin
                chk("out_a", ifa.out_data, qa.pop_front());
            end
        end
        if (!reset && ifb.out_valid && out_ready) begin
            if (qb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out_b_extra: got %0d expected none", ifb.out_data);
            end else begin
                chk("out_b", ifb.out_data, qb.pop_front());
            end
        end
        if (done_a) begin
            done_cnt_a++;
            chk("busy_on_done_a", busy_a, 0);
        end
        if (done_b) begin
            done_cnt_b++;
            chk("busy_on_done_b", busy_b, 0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (or_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Reference: max over each 2x2 window of the stored frame, then ReLU.
    task automatic build_exp(input int sel, input bit relu, input int stop_after);
        int w;
        int h;
        int last;
        logic signed [7:0] m;
        w = sel ? 8 : 4;
        h = sel ? 6 : 4;
        for (int r = 0; r < h / 2; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                m = fm[2 * r * w + 2 * c];
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++)
                        if (fm[(2 * r + dy) * w + 2 * c + dx] > m)
                            m = fm[(2 * r + dy) * w + 2 * c + dx];
                if (relu && m < 0) m = 0;
                last = (2 * r + 1) * w + 2 * c + 1;
                if (last < stop_after) begin
                    if (sel != 0) qb.push_back(m);
                    else qa.push_back(m);
                end
            end
        end
    endtask

    task automatic send_frame(input int sel, input bit relu,
                              input int stop_after, input bit gaps);
        int i;
        int guard;
        bit acc;
        build_exp(sel, relu, stop_after);
        @(posedge clk);
        #1;
        relu_en = relu;
        if (sel != 0) start_b = 1'b1;
        else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        i = 0;
        guard = 0;
        while (i < stop_after && guard < 5000) begin
            in_data  = fm[i];
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            acc = in_valid && ((sel != 0) ? ifb.in_ready : ifa.in_ready);
            @(posedge clk);
            #1;
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0;
        if (i < stop_after) begin
            tests++;
            fails++;
            $display("FAIL in_timeout: got %0d pixels expected %0d", i, stop_after);
        end
    endtask

    task automatic wait_done(input int sel, input string name);
        int base;
        int g;
        base = (sel != 0) ? done_cnt_b : done_cnt_a;
        g = 0;
        while (((sel != 0) ? done_cnt_b : done_cnt_a) == base && g < 3000) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk({name, "_done"}, ((sel != 0) ? done_cnt_b : done_cnt_a) - base, 1);
        chk({name, "_qempty"}, (sel != 0) ? qb.size() : qa.size(), 0);
    endtask

    task automatic fill_seq();
        for (int j = 0; j < 16; j++) fm[j] = 8'(j + 1);
    endtask

    task automatic fill_rand(input int n);
        for (int j = 0; j < n; j++) fm[j] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int g;
        int base;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", ifa.in_ready, 0);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_out_data", ifa.out_data, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_busy_b", busy_b, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Sequential 1..16 frame
        fill_seq();
        send_frame(0, 1'b0, 16, 1'b0);
        wait_done(0, "t1");

        // All -3, without and with ReLU
        for (int j = 0; j < 16; j++) fm[j] = -8'sd3;
        send_frame(0, 1'b0, 16, 1'b0);
        wait_done(0, "t2a");
        send_frame(0, 1'b1, 16, 1'b0);
        wait_done(0, "t2b");

        // Signed extremes
        fill_rand(16);
        fm[0] = 8'h80; fm[1] = 8'h7F; fm[4] = 8'h00; fm[5] = 8'hFF;
        fm[2] = 8'h80; fm[3] = 8'h81; fm[6] = 8'h80; fm[7] = 8'h80;
        send_frame(0, 1'b0, 16, 1'b0);
        wait_done(0, "t3");

        // Output backpressure
        fill_seq();
        or_mode = 2;
        out_ready = 1'b0;
        fork
            send_frame(0, 1'b0, 16, 1'b0);
            begin
                g = 0;
                while (!ifa.out_valid && g < 500) begin
                    @(negedge clk);
                    g++;
                end
                chk("bp_valid", ifa.out_valid, 1);
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    chk("bp_in_ready", ifa.in_ready, 0);
                    chk("bp_hold", ifa.out_data, 6);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                or_mode = 0;
            end
        join
        wait_done(0, "t4");

        // Random data and gaps on 8x6
        or_mode = 1;
        for (int f = 0; f < 3; f++) begin
            fill_rand(48);
            send_frame(1, 1'($urandom_range(0, 1)), 48, 1'b1);
            wait_done(1, "t5");
        end
        for (int f = 0; f < 2; f++) begin
            fill_rand(16);
            send_frame(0, 1'($urandom_range(0, 1)), 16, 1'b1);
            wait_done(0, "t5a");
        end
        or_mode = 0;
        out_ready = 1'b1;

        // Reset after 7 transfers
        fill_seq();
        base = done_cnt_a;
        send_frame(0, 1'b0, 7, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", ifa.out_valid, 0);
        chk("abort_busy", busy_a, 0);
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_cnt_a - base, 0);
        chk("abort_qempty", qa.size(), 0);
        send_frame(0, 1'b0, 16, 1'b0);
        wait_done(0, "t6a");

        // Start pulse mid-frame with relu toggled
        for (int j = 0; j < 16; j++) fm[j] = 8'(-$urandom_range(1, 128));
        fork
            send_frame(0, 1'b0, 16, 1'b0);
            begin
                repeat (8) @(posedge clk);
                #1;
                start_a = 1'b1;
                relu_en = 1'b1;
                @(posedge clk);
                #1;
                start_a = 1'b0;
            end
        join
        wait_done(0, "t6b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
